pipeline_fifo: RTL and testbench



---
 rtl/pipeline_fifo.sv | 109 ++++++++++
 tb/tb_pipeline_fifo.sv | 187 ++++++++++++++++++
 2 files changed

// File: rtl/pipeline_fifo.sv
// pipeline_fifo: elastic valid/ready buffer placed after `pipeline`.
// Stores up to Depth words in a circular buffer and presents the oldest one
// to a consumer that may stall. Reports occupancy and a sticky drop flag
// that is set whenever upstream offers a word while the buffer is full.
//
// Optional build macro: PIPELINE_FIFO_BYPASS_EN
//   defined   -> zero-latency bypass while empty. in_valid/in_data reach
//                out_valid/out_data combinationally.
//   undefined -> all outputs come from registered state.
//
// Ports:
//   clk        in   sole clock, posedge
//   rst        in   asynchronous, active-high reset
//   in_valid   in   upstream word present
//   in_data    in   upstream word [Width]
//   in_ready   out  buffer can accept a word (registered state only)
//   out_valid  out  head word present
//   out_data   out  head word [Width]
//   out_ready  in   consumer takes out_data this cycle
//   count      out  occupancy 0..Depth [$clog2(Depth+1)]
//   drop       out  sticky overflow flag, cleared only by rst
module pipeline_fifo #(
  parameter int unsigned Width = 15,
  parameter int unsigned Depth = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  input  logic [Width-1:0]           in_data,
  output logic                       in_ready,
  output logic                       out_valid,
  output logic [Width-1:0]           out_data,
  input  logic                       out_ready,
  output logic [$clog2(Depth+1)-1:0] count,
  output logic                       drop
);

  localparam int unsigned CW = $clog2(Depth + 1);
  localparam int unsigned PW = $clog2(Depth);
  localparam logic [CW-1:0] C_FULL = CW'(Depth);
  localparam logic [CW-1:0] C_ONE  = CW'(1);
  localparam logic [PW-1:0] P_LAST = PW'(Depth - 1);
  localparam logic [PW-1:0] P_ONE  = PW'(1);

  logic [Width-1:0] r_mem [Depth];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             r_drop;

  logic w_full;
  logic w_empty;
  logic w_push;
  logic w_pop;

  assign w_full   = (r_count == C_FULL);
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign count    = r_count;
  assign drop     = r_drop;

`ifdef PIPELINE_FIFO_BYPASS_EN
  // While empty the incoming word is presented directly; it is only stored
  // if the consumer does not take it in the same cycle.
  assign out_valid = !w_empty || in_valid;
  assign out_data  = w_empty ? in_data : r_mem[r_rd_ptr];
  assign w_push    = in_valid && !w_full && !(w_empty && out_ready);
  assign w_pop     = !w_empty && out_ready;
`else
  assign out_valid = !w_empty;
  assign out_data  = r_mem[r_rd_ptr];
  assign w_push    = in_valid && !w_full;
  assign w_pop     = !w_empty && out_ready;
`endif

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == P_LAST) ? '0 : p + P_ONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_drop   <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= in_data;
        r_wr_ptr        <= next_ptr(r_wr_ptr);
      end
      if (w_pop) begin
        r_rd_ptr <= next_ptr(r_rd_ptr);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + C_ONE;
        2'b01:   r_count <= r_count - C_ONE;
        default: r_count <= r_count;
      endcase
      if (in_valid && w_full) begin
        r_drop <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pipeline_fifo.sv
module tb_pipeline_fifo;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance A: Depth 4
  logic        a_in_valid = 1'b0;
  logic [14:0] a_in_data  = '0;
  logic        a_in_ready;
  logic        a_out_valid;
  logic [14:0] a_out_data;
  logic        a_out_ready = 1'b0;
  logic [2:0]  a_count;
  logic        a_drop;

  // Instance B: Depth 3 (non-power-of-two wrap)
  logic        b_in_valid = 1'b0;
  logic [14:0] b_in_data  = '0;
  logic        b_in_ready;
  logic        b_out_valid;
  logic [14:0] b_out_data;
  logic        b_out_ready = 1'b0;
  logic [1:0]  b_count;
  logic        b_drop;

  pipeline_fifo #(.Width(15), .Depth(4)) u_a (
    .clk(clk), .rst(rst),
    .in_valid(a_in_valid), .in_data(a_in_data), .in_ready(a_in_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_ready(a_out_ready),
    .count(a_count), .drop(a_drop)
  );

  pipeline_fifo #(.Width(15), .Depth(3)) u_b (
    .clk(clk), .rst(rst),
    .in_valid(b_in_valid), .in_data(b_in_data), .in_ready(b_in_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_ready(b_out_ready),
    .count(b_count), .drop(b_drop)
  );

  int unsigned n_tests = 0;
  int unsigned n_fail  = 0;

  // Scoreboard state: words expected out, in order, plus sticky drop.
  logic [14:0] sbq[$];
  logic        m_drop = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear before any edge.
  task automatic do_reset;
    @(negedge clk);
    a_in_valid = 1'b0; a_out_ready = 1'b0;
    b_in_valid = 1'b0; b_out_ready = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rst_a_count", 32'(a_count), 0);
    check("rst_a_out_valid", 32'(a_out_valid), 0);
    check("rst_a_out_data", 32'(a_out_data), 0);
    check("rst_a_in_ready", 32'(a_in_ready), 1);
    check("rst_a_drop", 32'(a_drop), 0);
    check("rst_b_count", 32'(b_count), 0);
    check("rst_b_in_ready", 32'(b_in_ready), 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    sbq.delete();
    m_drop = 1'b0;
  endtask

  // One cycle on instance `which` (0 = A depth 4, 1 = B depth 3).
  // Called at posedge+1; checks current outputs against the scoreboard,
  // updates the scoreboard with what this edge should do, then clocks.
  task automatic step(input int unsigned which, input logic v, input logic [14:0] d, input logic r);
    int unsigned depth;
    int unsigned sz;
    logic [31:0] cnt, ov, ir, dr;
    logic [14:0] od;
    depth = (which == 0) ? 4 : 3;
    if (which == 0) begin
      a_in_valid = v; a_in_data = d; a_out_ready = r;
      cnt = 32'(a_count); ov = 32'(a_out_valid); ir = 32'(a_in_ready);
      dr = 32'(a_drop); od = a_out_data;
    end else begin
      b_in_valid = v; b_in_data = d; b_out_ready = r;
      cnt = 32'(b_count); ov = 32'(b_out_valid); ir = 32'(b_in_ready);
      dr = 32'(b_drop); od = b_out_data;
    end
    sz = sbq.size();
    check("count", cnt, sz);
    check("out_valid", ov, 32'(sz != 0));
    check("in_ready", ir, 32'(sz != depth));
    check("drop", dr, 32'(m_drop));
    if (sz != 0 && r) begin
      logic [14:0] e;
      e = sbq.pop_front();
      check("pop_data", 32'(od), 32'(e));
    end
    if (v) begin
      if (sz != depth) sbq.push_back(d);
      else m_drop = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        v;
    logic [14:0] d;
    logic        r;
    logic [2:0]  e_count;
    logic        e_in_ready;
    logic        e_out_valid;
    logic [14:0] e_out_data;
    logic        e_drop;
  } vec_t;

  vec_t vecs[9];

  initial begin
    // Fill, overflow, full-with-pop, drain. Expectations are after the edge.
    vecs[0] = '{1'b1, 15'h1111, 1'b0, 3'd1, 1'b1, 1'b1, 15'h1111, 1'b0};
    vecs[1] = '{1'b1, 15'h2222, 1'b0, 3'd2, 1'b1, 1'b1, 15'h1111, 1'b0};
    vecs[2] = '{1'b1, 15'h3333, 1'b0, 3'd3, 1'b1, 1'b1, 15'h1111, 1'b0};
    vecs[3] = '{1'b1, 15'h4444, 1'b0, 3'd4, 1'b0, 1'b1, 15'h1111, 1'b0};
    vecs[4] = '{1'b1, 15'h5555, 1'b0, 3'd4, 1'b0, 1'b1, 15'h1111, 1'b1};
    vecs[5] = '{1'b1, 15'h5555, 1'b1, 3'd3, 1'b1, 1'b1, 15'h2222, 1'b1};
    vecs[6] = '{1'b0, 15'h0000, 1'b1, 3'd2, 1'b1, 1'b1, 15'h3333, 1'b1};
    vecs[7] = '{1'b0, 15'h0000, 1'b1, 3'd1, 1'b1, 1'b1, 15'h4444, 1'b1};
    vecs[8] = '{1'b0, 15'h0000, 1'b1, 3'd0, 1'b1, 1'b0, 15'h0000, 1'b1};

    do_reset();

    // Table-driven fill and stall
    for (int i = 0; i < 9; i++) begin
      a_in_valid = vecs[i].v; a_in_data = vecs[i].d; a_out_ready = vecs[i].r;
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_count", i), 32'(a_count), 32'(vecs[i].e_count));
      check($sformatf("vec%0d_in_ready", i), 32'(a_in_ready), 32'(vecs[i].e_in_ready));
      check($sformatf("vec%0d_out_valid", i), 32'(a_out_valid), 32'(vecs[i].e_out_valid));
      check($sformatf("vec%0d_drop", i), 32'(a_drop), 32'(vecs[i].e_drop));
      if (vecs[i].e_out_valid)
        check($sformatf("vec%0d_out_data", i), 32'(a_out_data), 32'(vecs[i].e_out_data));
    end
    a_in_valid = 1'b0; a_out_ready = 1'b0;

    // Streaming 1..100 with consumer always ready
    do_reset();
    for (int i = 1; i <= 100; i++) step(0, 1'b1, 15'(i), 1'b1);
    step(0, 1'b0, '0, 1'b1);
    step(0, 1'b0, '0, 1'b1);

    // Wrap-around on depth 3: two pushes then one pop, random data
    do_reset();
    for (int i = 0; i < 12; i++) begin
      if (i % 3 != 2) step(1, 1'b1, 15'($urandom), 1'b0);
      else            step(1, 1'b0, '0, 1'b1);
    end
    for (int i = 0; i < 5; i++) step(1, 1'b0, '0, 1'b1);
    // Reuse across the wrap point with mixed traffic
    for (int i = 0; i < 30; i++) step(1, 1'($urandom), 15'($urandom), 1'($urandom));
    for (int i = 0; i < 4; i++) step(1, 1'b0, '0, 1'b1);

    // Mid-operation reset with two words buffered
    do_reset();
    step(0, 1'b1, 15'h0123, 1'b0);
    step(0, 1'b1, 15'h0456, 1'b0);
    check("pre_rst_count", 32'(a_count), 2);
    do_reset();
    step(0, 1'b1, 15'h0ABC, 1'b1);
    step(0, 1'b0, '0, 1'b1);
    step(0, 1'b0, '0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
